if_fetch_unit: RTL
==================

# if_fetch_unit

Instruction-fetch stage feeding the IF/ID pipeline register. Holds the program counter, issues one-outstanding-request fetches to instruction memory, buffers a returned instruction while the pipeline is stalled, and drops wrong-path fetches on a branch redirect. It generates the IF/ID write-enable, flush and data (PC+4, instruction) so that a bubble is inserted whenever no valid instruction is available.

## Interface
- ADDR_W, 32, PC / instruction-memory address width
- DATA_W, 32, instruction width
- RESET_PC, 0, first fetch address after reset
- clk_i  in  1  clock, all state on rising edge
- rst_i  in  1  reset, asynchronous, active-low
- stall_i  in  1  hazard stall from ID; IF/ID must hold
- redirect_i  in  1  taken branch/jump resolved downstream
- redirect_pc_i  in  ADDR_W  target PC; bits [1:0] ignored (treated as 0)
- imem_req_o  out  1  one-cycle fetch request pulse
- imem_addr_o  out  ADDR_W  fetch address, valid with imem_req_o
- imem_valid_i  in  1  one-cycle response strobe, at least 1 cycle after request
- imem_data_i  in  DATA_W  instruction, valid with imem_valid_i
- ifid_write_o  out  1  IF/ID write enable
- ifid_flush_o  out  1  IF/ID flush (loads zero/NOP)
- ifid_data_o  out  ADDR_W+DATA_W  {pc_plus4, instr} to IF/ID data input

## Operation
- State register pc_q (PC of instruction currently being fetched), instr_q (hold buffer), state.
- States: RST, REQ, WAIT, HOLD, DROP.
- RST: entered on reset; no request. Next: REQ.
- REQ: imem_req_o=1, imem_addr_o=pc_q. Next WAIT; if redirect_i, pc_q<=redirect_pc_i, next DROP.
- WAIT: avail=imem_valid_i, instr=imem_data_i (bypass). avail & !stall_i: pc_q<=pc_q+4, next REQ. avail & stall_i: instr_q<=imem_data_i, next HOLD. !avail: stay.
- HOLD: avail=1, instr=instr_q. !stall_i: pc_q<=pc_q+4, next REQ; else stay.
- DROP: response of the killed request is ignored; on imem_valid_i next REQ, else stay.
- Redirect priority (all states except RST): pc_q<=redirect_pc_i; go REQ if no request outstanding (HOLD, or WAIT/DROP with imem_valid_i this cycle); otherwise DROP. Redirect in DROP updates pc_q again.
- Combinational outputs: ifid_write_o = avail & !stall_i & !redirect_i; ifid_flush_o = redirect_i | (!stall_i & !avail); ifid_data_o = {pc_q+4, instr}, instr=0 when !avail.
- Arithmetic: pc_q+4 wraps modulo 2^ADDR_W; no overflow flag.
- Never more than one request outstanding; imem_req_o only in REQ.

## Timing
- Reset values: state=RST, pc_q=RESET_PC, instr_q=0, imem_req_o=0, imem_addr_o=RESET_PC, ifid_write_o=0, ifid_flush_o=1 (bubble), ifid_data_o={RESET_PC+4, 0}.
- First request: second rising edge after rst_i deasserts (RST then REQ).
- Fetch latency: instruction written into IF/ID on the edge closing the imem_valid_i cycle; with 1-cycle memory latency, peak throughput one instruction per 2 cycles.
- stall_i and redirect_i sampled same cycle: redirect wins, flush asserted, write deasserted.
- Reset mid-operation: all state to reset values immediately; instruction memory shares rst_i and discards outstanding requests; any imem_valid_i in RST ignored.

## Structure
- Shared package cpu_pkg: fetch state enum, NOP encoding (all-zero), ADDR_W/DATA_W defaults, instruction step constant 4.
- One sub-module: if_hold_buf (instr_q capture on valid&stall, release on !stall, clear on redirect).

## Test plan
- Reset release, memory latency 1, no stall -> requests at 0x0, 0x4, 0x8 every 2 cycles; IF/ID writes {0x4,I0},{0x8,I1}; flush on alternate cycles.
- Response arrives with stall_i=1 for 3 cycles -> HOLD, ifid_write_o=0, flush=0 for 3 cycles, then writes {pc+4, held instr}; next request addr=pc+4.
- redirect_i to 0x100 during WAIT, response 2 cycles later -> response dropped, flush=1 in redirect cycle, next request addr=0x100.
- redirect_i and imem_valid_i same cycle, redirect_pc=0x203 -> no write, flush=1, next cycle request addr=0x200.
- pc_q=0xFFFFFFFC fetch -> ifid_data_o pc_plus4=0x0, next request addr 0x0.
- rst_i asserted while in WAIT -> outputs to reset values asynchronously; after release first request addr=RESET_PC.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared CPU definitions: fetch FSM state encoding, default widths,
// NOP encoding and the sequential instruction step.
package cpu_pkg;

    localparam int ADDR_W_DEF = 32;
    localparam int DATA_W_DEF = 32;
    localparam int INSTR_STEP = 4;
    localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

    typedef enum logic [2:0] {
        ST_RST  = 3'd0,
        ST_REQ  = 3'd1,
        ST_WAIT = 3'd2,
        ST_HOLD = 3'd3,
        ST_DROP = 3'd4
    } fetch_state_e;

endpackage

// File: rtl/if_hold_buf.sv
// Holds a returned instruction while the pipeline is stalled; emptied when
// the stall releases or a redirect makes the held instruction wrong-path.
module if_hold_buf
    import cpu_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              capture,
    input  logic              drain,
    input  logic              clear,
    input  logic [DATA_W-1:0] data_in,
    output logic [DATA_W-1:0] data_held
);

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            data_held <= '0;
        end else if (clear || drain) begin
            data_held <= '0;
        end else if (capture) begin
            data_held <= data_in;
        end
    end

endmodule

// File: rtl/if_fetch_unit.sv
// Instruction-fetch stage: PC, single-outstanding imem fetch, stall hold
// buffer and wrong-path drop, producing IF/ID write/flush/data.
//
// state   | meaning
// --------+--------------------------------------------------------------
// ST_RST  | just out of reset, no request yet
// ST_REQ  | issuing fetch for pc_q
// ST_WAIT | request outstanding, response bypassed straight to IF/ID
// ST_HOLD | response captured while stalled, waiting for stall release
// ST_DROP | redirected with a request in flight; discard its response
module if_fetch_unit
    import cpu_pkg::*;
#(
    parameter int              ADDR_W   = ADDR_W_DEF,
    parameter int              DATA_W   = DATA_W_DEF,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     stall_i,
    input  logic                     redirect_i,
    input  logic [ADDR_W-1:0]        redirect_pc_i,
    output logic                     imem_req_o,
    output logic [ADDR_W-1:0]        imem_addr_o,
    input  logic                     imem_valid_i,
    input  logic [DATA_W-1:0]        imem_data_i,
    output logic                     ifid_write_o,
    output logic                     ifid_flush_o,
    output logic [ADDR_W+DATA_W-1:0] ifid_data_o
);

    fetch_state_e      state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [ADDR_W-1:0] pc_step;
    logic [ADDR_W-1:0] redirect_pc;
    logic [DATA_W-1:0] instr, instr_held;
    logic              avail, capture, drain, clear;

    assign pc_step     = pc_q + ADDR_W'(INSTR_STEP);
    assign redirect_pc = {redirect_pc_i[ADDR_W-1:2], 2'b00};
    assign clear       = redirect_i && (state_q != ST_RST);

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q <= ST_RST;
            pc_q    <= RESET_PC;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
        end
    end

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        avail   = 1'b0;
        instr   = DATA_W'(NOP_INSTR);
        capture = 1'b0;
        drain   = 1'b0;
        case (state_q)
            ST_RST: state_d = ST_REQ;
            ST_REQ: state_d = ST_WAIT;
            ST_WAIT: begin
                avail = imem_valid_i;
                if (imem_valid_i) begin
                    instr = imem_data_i;
                    if (!stall_i) begin
                        pc_d    = pc_step;
                        state_d = ST_REQ;
                    end else begin
                        capture = 1'b1;
                        state_d = ST_HOLD;
                    end
                end
            end
            ST_HOLD: begin
                avail = 1'b1;
                instr = instr_held;
                if (!stall_i) begin
                    drain   = 1'b1;
                    pc_d    = pc_step;
                    state_d = ST_REQ;
                end
            end
            ST_DROP: begin
                if (imem_valid_i) state_d = ST_REQ;
            end
            default: state_d = ST_RST;
        endcase

        // A redirect may only re-request once nothing is left in flight.
        if (clear) begin
            pc_d    = redirect_pc;
            capture = 1'b0;
            if (state_q == ST_HOLD ||
                ((state_q == ST_WAIT || state_q == ST_DROP) && imem_valid_i))
                state_d = ST_REQ;
            else
                state_d = ST_DROP;
        end
    end

    if_hold_buf #(.DATA_W(DATA_W)) u_hold_buf (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .capture   (capture),
        .drain     (drain),
        .clear     (clear),
        .data_in   (imem_data_i),
        .data_held (instr_held)
    );

    assign imem_req_o   = (state_q == ST_REQ);
    assign imem_addr_o  = pc_q;
    assign ifid_write_o = avail && !stall_i && !redirect_i;
    assign ifid_flush_o = redirect_i || (!stall_i && !avail);
    assign ifid_data_o  = {pc_step, instr};

endmodule
